uart_tx_arb: RTL and testbench

//  Round-robin arbiter sharing the single UART transmit byte port among NREQ requesters (CPU store path,

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_arb_rr_pick.sv | 33 +++
 rtl/uart_tx_arb.sv | 137 +++++++++++++
 tb/tb_uart_tx_arb.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width and FSM state encoding.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [PW-1:0]   idx,
    output logic            any
);

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int k);
        int s;
        s = (int'(p) + k) % NREQ;
        return PW'(s);
    endfunction

    // NOTE: every output gets a default before the scan so no path leaves a value held (no latch).
    always_comb begin
        gnt_onehot = '0;
        idx        = '0;
        any        = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any && req[wrap_idx(ptr, k)]) begin
                gnt_onehot[wrap_idx(ptr, k)] = 1'b1;
                idx                          = wrap_idx(ptr, k);
                any                          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Message-locked round-robin arbiter sharing the uart0 transmit byte port; all outputs registered.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          last,
    input  logic [NREQ*UART_BYTE_W-1:0] data,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          gnt,
    output logic                     txd_ld,
    output logic [UART_BYTE_W-1:0]   txd_dat,
    input  logic                     txd_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [PW-1:0] PTR_RST    = PW'(NREQ - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_e             state_q, state_d;
    logic [PW-1:0]          owner_q, owner_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [BW-1:0]          burst_q, burst_d;
    logic                   lst_q, lst_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic [NREQ-1:0]        ack_q, ack_d;
    logic                   txd_ld_q, txd_ld_d;
    logic [UART_BYTE_W-1:0] txd_dat_q, txd_dat_d;

    logic [NREQ-1:0]        pick_gnt;
    logic [PW-1:0]          pick_idx;
    logic                   pick_any;
    logic [UART_BYTE_W-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign data_arr[i] = data[UART_BYTE_W*i +: UART_BYTE_W];
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .gnt_onehot (pick_gnt),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        lst_d     = lst_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        txd_ld_d  = 1'b0;
        txd_dat_d = txd_dat_q;

        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    owner_d = pick_idx;
                    burst_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q;
                    gnt_d   = '0;
                end else if (!txd_busy) begin
                    txd_dat_d = data_arr[owner_q];
                    lst_d     = last[owner_q];
                    txd_ld_d  = 1'b1;
                    ack_d     = gnt_q;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                // The strobe cycle also lets the FIFO full flag settle before the next LOAD.
                if (lst_q || burst_q == BURST_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q;
                    gnt_d   = '0;
                end else begin
                    burst_d = burst_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= PTR_RST;
            burst_q   <= '0;
            lst_q     <= 1'b0;
            gnt_q     <= '0;
            ack_q     <= '0;
            txd_ld_q  <= 1'b0;
            txd_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            burst_q   <= burst_d;
            lst_q     <= lst_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            txd_ld_q  <= txd_ld_d;
            txd_dat_q <= txd_dat_d;
        end
    end

    assign ack     = ack_q;
    assign gnt     = gnt_q;
    assign txd_ld  = txd_ld_q;
    assign txd_dat = txd_dat_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb: requester queues drive the DUT, a transaction-level
// round-robin model predicts the byte order, and per-cycle checks cover the strobe protocol.
module tb_uart_tx_arb;

    localparam int NREQ      = 2;
    localparam int MAX_BURST = 4;

    typedef struct {
        logic [7:0] b;
        logic       l;
    } msg_t;

    typedef struct {
        int         own;
        logic [7:0] b;
    } xfer_t;

    typedef struct {
        int         own;
        logic [7:0] b;
        logic [1:0] g;
        int         cyc;
    } obs_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  last = '0;
    logic [15:0] data = '0;
    logic [1:0]  ack;
    logic [1:0]  gnt;
    logic        txd_ld;
    logic [7:0]  txd_dat;
    logic        txd_busy = 1'b0;

    msg_t  mq0[$];
    msg_t  mq1[$];
    xfer_t exp_q[$];
    obs_t  obs[$];
    logic [1:0] drop = '0;
    logic  busy_rand = 1'b0;
    logic  prev_ld = 1'b0;
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;

    uart_tx_arb #(
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .last     (last),
        .data     (data),
        .ack      (ack),
        .gnt      (gnt),
        .txd_ld   (txd_ld),
        .txd_dat  (txd_dat),
        .txd_busy (txd_busy)
    );

    always #5 clk = ~clk;

    task automatic drive();
        req[0]     = (mq0.size() > 0) && !drop[0];
        data[7:0]  = (mq0.size() > 0) ? mq0[0].b : 8'h00;
        last[0]    = (mq0.size() > 0) ? mq0[0].l : 1'b0;
        req[1]     = (mq1.size() > 0) && !drop[1];
        data[15:8] = (mq1.size() > 0) ? mq1[0].b : 8'h00;
        last[1]    = (mq1.size() > 0) ? mq1[0].l : 1'b0;
        if (busy_rand) txd_busy = ($urandom_range(0, 3) == 0);
    endtask

    // One clock: sample outputs at the falling edge, check protocol, then update requesters.
    task automatic step();
        logic busy_at_edge;
        busy_at_edge = txd_busy;
        @(negedge clk);
        cyc++;
        checks++;
        if (ack !== (txd_ld ? gnt : 2'b00) || $countones(gnt) > 1 || (txd_ld && gnt == 2'b00)) begin
            errors++;
            $display("FAIL proto cyc=%0d ack=%b gnt=%b txd_ld=%b", cyc, ack, gnt, txd_ld);
        end
        checks++;
        if (txd_ld && (prev_ld || busy_at_edge)) begin
            errors++;
            $display("FAIL strobe_rule cyc=%0d prev_ld=%b busy=%b", cyc, prev_ld, busy_at_edge);
        end
        if (txd_ld) begin
            obs.push_back('{own: (ack == 2'b10) ? 1 : 0, b: txd_dat, g: gnt, cyc: cyc});
        end
        if (ack[0] && mq0.size() > 0) mq0.delete(0);
        if (ack[1] && mq1.size() > 0) mq1.delete(0);
        prev_ld = txd_ld;
        drive();
    endtask

    // Reference: round-robin over pending messages, a grant ends on last byte, MAX_BURST or empty queue.
    task automatic build_exp();
        msg_t c0[$];
        msg_t c1[$];
        msg_t m;
        int   ptr;
        int   j;
        int   n;
        logic done;
        c0  = mq0;
        c1  = mq1;
        ptr = NREQ - 1;
        exp_q.delete();
        forever begin
            j = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int jj;
                jj = (ptr + k) % NREQ;
                if (j < 0 && ((jj == 0) ? c0.size() : c1.size()) > 0) j = jj;
            end
            if (j < 0) break;
            n    = 0;
            done = 1'b0;
            while (!done) begin
                if (j == 0) begin m = c0[0]; c0.delete(0); end
                else        begin m = c1[0]; c1.delete(0); end
                exp_q.push_back('{own: j, b: m.b});
                n++;
                done = m.l || n == MAX_BURST || ((j == 0) ? c0.size() : c1.size()) == 0;
            end
            ptr = j;
        end
    endtask

    task automatic run_idle(input string name, input int max_cyc);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            step();
            n++;
            done = mq0.size() == 0 && mq1.size() == 0 && gnt == 2'b00 && !txd_ld;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout cycles=%0d left0=%0d left1=%0d", name, n, mq0.size(), mq1.size());
        end
    endtask

    task automatic cmp_seq(input string name);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got=%0d want=%0d", name, obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i].own !== exp_q[i].own || obs[i].b !== exp_q[i].b) begin
                errors++;
                $display("FAIL %s[%0d] got=%0d:%h want=%0d:%h", name, i,
                         obs[i].own, obs[i].b, exp_q[i].own, exp_q[i].b);
            end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (ack !== 2'b00 || gnt !== 2'b00 || txd_ld !== 1'b0 || txd_dat !== 8'h00) begin
            errors++;
            $display("FAIL %s ack=%b gnt=%b txd_ld=%b txd_dat=%h want all zero",
                     name, ack, gnt, txd_ld, txd_dat);
        end
    endtask

    task automatic do_reset();
        clr       = 1'b1;
        txd_busy  = 1'b0;
        busy_rand = 1'b0;
        drop      = '0;
        mq0.delete();
        mq1.delete();
        drive();
        #1;
        check_zero_outputs("reset_outputs");
        @(negedge clk);
        clr     = 1'b0;
        prev_ld = 1'b0;
        obs.delete();
    endtask

    task automatic push_msg(input int r, input logic [7:0] b, input logic l);
        if (r == 0) mq0.push_back('{b: b, l: l});
        else        mq1.push_back('{b: b, l: l});
    endtask

    task automatic test_reset();
        #2;
        check_zero_outputs("reset_initial");
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        push_msg(0, 8'h41, 1'b0);
        push_msg(0, 8'h42, 1'b0);
        push_msg(0, 8'h43, 1'b1);
        build_exp();
        drive();
        run_idle("single", 50);
        cmp_seq("single");
        for (int i = 0; i < obs.size(); i++) begin
            checks++;
            if (obs[i].g !== 2'b01) begin
                errors++;
                $display("FAIL single_gnt[%0d] got=%b want=01", i, obs[i].g);
            end
            if (i > 0) begin
                checks++;
                if (obs[i].cyc - obs[i-1].cyc != 2) begin
                    errors++;
                    $display("FAIL single_spacing[%0d] got=%0d want=2", i, obs[i].cyc - obs[i-1].cyc);
                end
            end
        end
        checks++;
        if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL single_release gnt=%b want=00", gnt);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        push_msg(0, 8'hA0, 1'b0); push_msg(0, 8'hA1, 1'b1);
        push_msg(0, 8'hA2, 1'b0); push_msg(0, 8'hA3, 1'b1);
        push_msg(1, 8'hB0, 1'b0); push_msg(1, 8'hB1, 1'b1);
        push_msg(1, 8'hB2, 1'b0); push_msg(1, 8'hB3, 1'b1);
        build_exp();
        drive();
        run_idle("rr", 100);
        cmp_seq("rr");
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 0; i < 8; i++) push_msg(0, 8'h00 + 8'(i), 1'b0);
        push_msg(1, 8'hC0, 1'b0);
        push_msg(1, 8'hC1, 1'b1);
        build_exp();
        drive();
        run_idle("burst", 100);
        cmp_seq("burst");

        // Sole requester past MAX_BURST: same owner again after exactly one idle cycle.
        do_reset();
        for (int i = 0; i < 6; i++) push_msg(0, 8'hD0 + 8'(i), i == 5);
        build_exp();
        drive();
        run_idle("solo", 100);
        cmp_seq("solo");
        checks++;
        if (obs.size() < 5 || obs[4].cyc - obs[3].cyc != 3) begin
            errors++;
            $display("FAIL solo_rotation_gap got=%0d want=3",
                     (obs.size() < 5) ? -1 : obs[4].cyc - obs[3].cyc);
        end
    endtask

    task automatic test_busy();
        int n;
        do_reset();
        txd_busy = 1'b1;
        push_msg(0, 8'h5A, 1'b1);
        drive();
        step();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL busy_grant gnt=%b want=01", gnt);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (txd_ld !== 1'b0 || ack !== 2'b00 || gnt !== 2'b01) begin
                errors++;
                $display("FAIL busy_hold[%0d] txd_ld=%b ack=%b gnt=%b want 0/00/01", i, txd_ld, ack, gnt);
            end
        end
        txd_busy = 1'b0;
        n = 0;
        while (!txd_ld && n < 5) begin
            step();
            n++;
        end
        checks++;
        if (!txd_ld || n > 2 || txd_dat !== 8'h5A) begin
            errors++;
            $display("FAIL busy_release cycles=%0d txd_ld=%b txd_dat=%h want <=2/1/5a", n, txd_ld, txd_dat);
        end
        run_idle("busy", 20);
    endtask

    task automatic test_withdraw();
        do_reset();
        push_msg(0, 8'h55, 1'b1);
        push_msg(1, 8'h66, 1'b1);
        drive();
        step();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL withdraw_grant gnt=%b want=01", gnt);
        end
        drop[0] = 1'b1;
        drive();
        step();
        checks++;
        if (gnt !== 2'b00 || txd_ld !== 1'b0 || ack !== 2'b00) begin
            errors++;
            $display("FAIL withdraw_release gnt=%b txd_ld=%b ack=%b want 00/0/00", gnt, txd_ld, ack);
        end
        step();
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL withdraw_next gnt=%b want=10", gnt);
        end
        mq0.delete();
        drop = '0;
        build_exp();
        drive();
        run_idle("withdraw", 50);
        cmp_seq("withdraw");
    endtask

    task automatic test_clr_mid();
        int n;
        do_reset();
        push_msg(0, 8'h10, 1'b0); push_msg(0, 8'h11, 1'b0); push_msg(0, 8'h12, 1'b1);
        push_msg(1, 8'h20, 1'b1);
        drive();
        n = 0;
        while (!txd_ld && n < 6) begin step(); n++; end
        #2 clr = 1'b1;
        #1 check_zero_outputs("clr_in_gap");
        step();
        clr = 1'b0;
        obs.delete();
        n = 0;
        while (gnt == 2'b00 && n < 6) begin step(); n++; end
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL clr_first_winner gnt=%b want=01", gnt);
        end
        #2 clr = 1'b1;
        #1 check_zero_outputs("clr_in_load");
        step();
        clr = 1'b0;
        checks++;
        if (mq0.size() != 2) begin
            errors++;
            $display("FAIL clr_pending got=%0d want=2", mq0.size());
        end
        obs.delete();
        build_exp();
        drive();
        run_idle("clr", 60);
        cmp_seq("clr");
    endtask

    task automatic test_random();
        for (int round = 0; round < 6; round++) begin
            do_reset();
            for (int r = 0; r < NREQ; r++) begin
                int nmsg;
                nmsg = $urandom_range(0, 3);
                for (int m = 0; m < nmsg; m++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) push_msg(r, 8'($urandom), b == len - 1);
                end
            end
            busy_rand = (round >= 3);
            build_exp();
            drive();
            run_idle("random", 2000);
            cmp_seq("random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_busy();
        test_withdraw();
        test_clr_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
